// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. A single full-adder cell (two half adders plus
//   an OR) consumes one operand bit per clock, LSB first. A start/busy/done
//   handshake launches a computation; the result is registered and held until
//   the next result replaces it.
//
// Handshake: start is sampled only while busy=0 (IDLE or DONE). An accepted
//   start captures a, b and cin on that edge. done is a single-cycle pulse,
//   and sum/cout are valid from that cycle on. A start seen while busy=1 is
//   dropped, not queued.
//
// Optional feature (macro SERIAL_ADDER_SUB_EN):
//   Adds input `sub`. With sub=1 the captured B is ~b and the initial carry is
//   1 (cin ignored), giving a-b mod 2^WIDTH; cout=1 then means no borrow.
//   With the macro undefined the block is a plain adder with no `sub` port.
//
// Parameters:
//   WIDTH      operand/result width, 1..64
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      computation request
//   a, b       operands, captured on accepted start
//   cin        carry-in, captured on accepted start
//   sub        subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy       high while a computation is in progress
//   done       single-cycle completion pulse
//   sum        registered result (mod 2^WIDTH)
//   cout       registered carry-out of the MSB
//   state_dbg  current FSM state (0=IDLE, 1=RUN, 2=DONE) for observation
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;

    logic             s_d;
    logic             c_d;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] b_cap_d;
    logic             c_cap_d;
    logic             last_bit;

    // Full-adder cell built from two half adders and an OR.
    logic ha1_s;
    logic ha1_c;
    assign ha1_s = a_q[0] ^ b_q[0];
    assign ha1_c = a_q[0] & b_q[0];
    assign s_d   = ha1_s ^ c_q;
    assign c_d   = ha1_c | (ha1_s & c_q);

    // New sum bit enters at the MSB so that after WIDTH shifts the LSB
    // computed first has arrived at bit 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_d = s_d;
        end else begin : g_res_wn
            assign res_d = {s_d, res_q[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as a + ~b + 1.
    assign b_cap_d = sub ? ~b : b;
    assign c_cap_d = sub ? 1'b1 : cin;
`else
    assign b_cap_d = b;
    assign c_cap_d = cin;
`endif

    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                // DONE accepts start exactly like IDLE, which gives
                // back-to-back operation at one result per WIDTH+1 cycles.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_cap_d;
                        c_q     <= c_cap_d;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= c_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_bit) begin
                        // Outputs load on the edge into DONE so they are
                        // valid in the same cycle as the done pulse.
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        sum     <= res_d;
                        cout    <= c_d;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed bench for serial_adder: a WIDTH=8 instance for the main cases and
//   a WIDTH=1 instance swept over all operand combinations. Expected results
//   are pushed to a queue when a start is driven and popped when done pulses.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- WIDTH=8 instance ----------------
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic [1:0]   st;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .state_dbg (st)
    );

    // ---------------- WIDTH=1 instance ----------------
    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;
    logic [1:0] st1;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub1;
`endif

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub1),
`endif
        .busy      (busy1),
        .done      (done1),
        .sum       (sum1),
        .cout      (cout1),
        .state_dbg (st1)
    );

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];
    logic [1:0] exp1_q[$];
    logic [W:0] last_res;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         lat;
    int         busy_cnt;
    int         dcnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    // Drives one start pulse; the caller guarantees the DUT is IDLE or DONE.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts, input bit push);
        a     = ta;
        b     = tb;
        cin   = tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = ts;
`endif
        start = 1'b1;
        if (push) begin
            if (ts)
                exp_q.push_back({1'b0, ta} + {1'b0, ~tb} + (W+1)'(1));
            else
                exp_q.push_back({1'b0, ta} + {1'b0, tb} + (W+1)'(tc));
        end
        step();
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
    endtask

    // Waits (bounded) for done; checks latency, held output during RUN and
    // the popped expected result. Returns in the DONE cycle.
    task automatic wait_done(input string tag);
        logic [W:0] e;
        while (!done && lat < W + 6) begin
            if (busy) busy_cnt++;
            if (lat == 3) check({tag, "_hold"}, {cout, sum}, last_res);
            step();
            lat++;
        end
        check({tag, "_lat"}, lat, W);
        check({tag, "_busy_low"}, busy, 1'b0);
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check({tag, "_res"}, {cout, sum}, e);
        last_res = e;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        cin1   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub    = 1'b0;
        sub1   = 1'b0;
`endif
        last_res = '0;

        // Reset then idle
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 1'b0);
        check("rst_state", st, 2'd0);

        // Basic add
        launch(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
        wait_done("add");
        check("add_busy_cycles", busy_cnt, W);
        check("add_state_done", st, 2'd2);
        step();
        check("add_done_pulse", done, 1'b0);
        check("add_idle_hold", {cout, sum}, 9'h096);
        step();

        // Wrap/carry then back-to-back start in the DONE cycle
        launch(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
        wait_done("wrap");
        launch(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        wait_done("b2b");
        step();
        step();

        // Start while busy is ignored
        launch(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
        step();
        step();
        a     = 8'hAA;
        start = 1'b1;
        step();
        start = 1'b0;
        lat   = 3;
        wait_done("ign");
        dcnt = 0;
        repeat (12) begin
            step();
            if (done) dcnt++;
        end
        check("ign_no_extra_done", dcnt, 0);

        // Reset mid-operation aborts without done
        launch(8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_sum", {cout, sum}, 9'h000);
        step();
        step();
        rst_n = 1'b1;
        last_res = '0;
        dcnt = 0;
        repeat (15) begin
            step();
            if (done) dcnt++;
        end
        check("midrst_no_done", dcnt, 0);
        check("midrst_state", st, 2'd0);

        // Carry-in with a mid-range value
        launch(8'h12, 8'h34, 1'b1, 1'b0, 1'b1);
        wait_done("cin");

`ifdef SERIAL_ADDER_SUB_EN
        launch(8'h05, 8'h07, 1'b0, 1'b1, 1'b1);
        wait_done("sub_borrow");
        launch(8'h07, 8'h05, 1'b1, 1'b1, 1'b1);
        wait_done("sub_noborrow");
        step();
`endif

        // A few random operands
        for (int i = 0; i < 4; i++) begin
            launch(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'b0, 1'b1);
            wait_done("rand");
            step();
        end

        // WIDTH=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            int         l;
            logic [2:0] v;
            logic [1:0] e1;
            v      = 3'(i);
            a1     = v[2];
            b1     = v[1];
            cin1   = v[0];
            start1 = 1'b1;
            exp1_q.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
            step();
            start1 = 1'b0;
            l = 0;
            while (!done1 && l < 6) begin
                step();
                l++;
            end
            check("w1_lat", l, 1);
            e1 = exp1_q.pop_front();
            check("w1_res", {cout1, sum1}, e1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
